// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one RV32I instruction per cycle, reads the
// owned register file (with same-cycle writeback bypass), tracks in-flight
// destinations in a busy-bit scoreboard, and registers the ALU bundle.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. in_ready is combinational and never depends on in_valid;
// out_valid only drops after a consume (out_ready) or a flush, and the
// bundle is held unchanged while out_valid & ~out_ready.
module decode_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        isRtype,
   output logic        isItype,
   output logic        isStype,
   output logic        isLtype,
   output logic        isJALR,
   output logic        isBtype,
   output logic        isJAL,
   output logic        isLUI,
   output logic        isAUIPC,
   output logic        illegal,
   output logic [2:0]  mem_funct3,
   output logic [4:0]  out_rd,
   output logic [31:0] out_rs2_data,
   output logic [31:0] out_imm,
   output logic [31:0] out_pc
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic [31:0] regs [0:31];
   logic [31:0] busy, busy_next;

   logic [4:0]  rs1, rs2, rd_field;
   logic [2:0]  f3_field;
   logic [6:0]  f7_field;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val;

   logic [31:0] d_in1, d_in2, d_imm;
   logic [2:0]  d_f3;
   logic [6:0]  d_f7;
   logic [4:0]  d_rd;
   logic        d_r, d_i, d_s, d_l, d_jalr, d_b, d_jal, d_lui, d_auipc, d_ill;
   logic        use1, use2, writes;
   logic        hazard, accept;

   assign rs1      = in_instr[19:15];
   assign rs2      = in_instr[24:20];
   assign rd_field = in_instr[11:7];
   assign f3_field = in_instr[14:12];
   assign f7_field = in_instr[31:25];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   // Source reads: x0 is hard zero, a writeback landing this cycle is forwarded
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : ((wb_en && wb_rd == rs1) ? wb_data : regs[rs1]);
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : ((wb_en && wb_rd == rs2) ? wb_data : regs[rs2]);

   // Opcode decode: type flags, operand selection, immediate and register usage
   always_comb begin
      d_r = 1'b0; d_i = 1'b0; d_s = 1'b0; d_l = 1'b0; d_jalr = 1'b0;
      d_b = 1'b0; d_jal = 1'b0; d_lui = 1'b0; d_auipc = 1'b0; d_ill = 1'b0;
      use1 = 1'b0; use2 = 1'b0; writes = 1'b0;
      d_in1 = 32'd0; d_in2 = 32'd0; d_imm = 32'd0;
      d_f3 = 3'd0; d_f7 = 7'd0;
      case (in_instr[6:0])
         OP_R: begin
            d_r = 1'b1; use1 = 1'b1; use2 = 1'b1; writes = 1'b1;
            d_in1 = rs1_val; d_in2 = rs2_val; d_f3 = f3_field; d_f7 = f7_field;
         end
         OP_IMM: begin
            d_i = 1'b1; use1 = 1'b1; writes = 1'b1;
            d_imm = imm_i; d_in1 = rs1_val; d_in2 = imm_i; d_f3 = f3_field;
            // Only the shift-immediates carry a meaningful funct7
            if (f3_field == 3'b001 || f3_field == 3'b101) d_f7 = f7_field;
         end
         OP_LOAD: begin
            d_l = 1'b1; use1 = 1'b1; writes = 1'b1;
            d_imm = imm_i; d_in1 = rs1_val; d_in2 = imm_i;
         end
         OP_STORE: begin
            d_s = 1'b1; use1 = 1'b1; use2 = 1'b1;
            d_imm = imm_s; d_in1 = rs1_val; d_in2 = imm_s;
         end
         OP_BR: begin
            d_b = 1'b1; use1 = 1'b1; use2 = 1'b1;
            d_imm = imm_b; d_in1 = rs1_val; d_in2 = rs2_val; d_f3 = f3_field;
         end
         OP_JAL: begin
            d_jal = 1'b1; d_i = 1'b1; writes = 1'b1;
            d_imm = imm_j; d_in1 = in_pc; d_in2 = 32'd4;
         end
         OP_JALR: begin
            d_jalr = 1'b1; use1 = 1'b1; writes = 1'b1;
            d_imm = imm_i; d_in1 = rs1_val; d_in2 = imm_i;
         end
         OP_LUI: begin
            d_lui = 1'b1; d_i = 1'b1; writes = 1'b1;
            d_imm = imm_u; d_in2 = imm_u;
         end
         OP_AUIPC: begin
            d_auipc = 1'b1; d_i = 1'b1; writes = 1'b1;
            d_imm = imm_u; d_in1 = in_pc; d_in2 = imm_u;
         end
         default: d_ill = 1'b1;
      endcase
   end

   assign d_rd = (writes && rd_field != 5'd0) ? rd_field : 5'd0;

   // RAW on a used source unless its writeback lands now; WAW on a busy destination
   assign hazard = (use1 && rs1 != 5'd0 && busy[rs1] && !(wb_en && wb_rd == rs1)) ||
                   (use2 && rs2 != 5'd0 && busy[rs2] && !(wb_en && wb_rd == rs2)) ||
                   (d_rd != 5'd0 && busy[d_rd]);

   assign in_ready = ~flush & (~out_valid | out_ready) & ~hazard;
   assign accept   = in_valid & in_ready;

   // Scoreboard next state: clears first so a same-index set wins
   always_comb begin
      busy_next = busy;
      if (wb_en) busy_next[wb_rd] = 1'b0;
      if (flush && out_valid && out_rd != 5'd0) busy_next[out_rd] = 1'b0;
      if (accept && d_rd != 5'd0) busy_next[d_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk) begin
      if (rst) busy <= 32'd0;
      else     busy <= busy_next;
   end

   // Register file write port; x0 is never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_en && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Output bundle register: load on accept, drop on consume or flush
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         alu_in1 <= 32'd0; alu_in2 <= 32'd0; funct3 <= 3'd0; funct7 <= 7'd0;
         isRtype <= 1'b0; isItype <= 1'b0; isStype <= 1'b0; isLtype <= 1'b0; isJALR <= 1'b0;
         isBtype <= 1'b0; isJAL <= 1'b0; isLUI <= 1'b0; isAUIPC <= 1'b0; illegal <= 1'b0;
         mem_funct3 <= 3'd0; out_rd <= 5'd0; out_rs2_data <= 32'd0; out_imm <= 32'd0; out_pc <= 32'd0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         alu_in1 <= d_in1; alu_in2 <= d_in2; funct3 <= d_f3; funct7 <= d_f7;
         isRtype <= d_r; isItype <= d_i; isStype <= d_s; isLtype <= d_l; isJALR <= d_jalr;
         isBtype <= d_b; isJAL <= d_jal; isLUI <= d_lui; isAUIPC <= d_auipc; illegal <= d_ill;
         mem_funct3 <= f3_field; out_rd <= d_rd; out_rs2_data <= rs2_val; out_imm <= d_imm; out_pc <= in_pc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: randomized fetch/writeback/flush/ready traffic,
// a table-driven reference decoder with its own register file and busy set,
// and a monitor that compares every presented bundle against the queue.
module tb_decode_issue;

   localparam int W = 188;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, wb_data;
   logic [4:0]  wb_rd, out_rd;
   logic [31:0] alu_in1, alu_in2, out_rs2_data, out_imm, out_pc;
   logic [2:0]  funct3, mem_funct3;
   logic [6:0]  funct7;
   logic        isRtype, isItype, isStype, isLtype, isJALR;
   logic        isBtype, isJAL, isLUI, isAUIPC, illegal;
   logic [W-1:0] act_bundle;

   logic [W-1:0] exp_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference state
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   logic        m_valid;
   logic [4:0]  m_held_rd;
   logic        m_just_reset;

   // clock/reset block
   always #5 clk = ~clk;

   decode_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .funct3(funct3), .funct7(funct7),
      .isRtype(isRtype), .isItype(isItype), .isStype(isStype), .isLtype(isLtype),
      .isJALR(isJALR), .isBtype(isBtype), .isJAL(isJAL), .isLUI(isLUI),
      .isAUIPC(isAUIPC), .illegal(illegal), .mem_funct3(mem_funct3),
      .out_rd(out_rd), .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_pc(out_pc)
   );

   assign act_bundle = {alu_in1, alu_in2, funct3, funct7,
                        isRtype, isItype, isStype, isLtype, isJALR,
                        isBtype, isJAL, isLUI, isAUIPC, illegal,
                        mem_funct3, out_rd, out_rs2_data, out_imm, out_pc};

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // 0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 illegal
   function automatic int class_of(input logic [6:0] opc);
      case (opc)
         7'h33: return 0;
         7'h13: return 1;
         7'h03: return 2;
         7'h23: return 3;
         7'h63: return 4;
         7'h6F: return 5;
         7'h67: return 6;
         7'h37: return 7;
         7'h17: return 8;
         default: return 9;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
      if (we && wrd == r) return wd;
      return m_regs[r];
   endfunction

   // Reference decoder built from the instruction-format rules
   function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] v1, input logic [31:0] v2,
                                      output logic [W-1:0] bnd, output logic [4:0] rd_o,
                                      output logic u1, output logic u2);
      int cls;
      logic writer;
      logic [31:0] sx, ii, is, ib, iu, ij, imm, a, b;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [9:0] fl;
      cls = class_of(ins[6:0]);
      writer = cls inside {0, 1, 2, 5, 6, 7, 8};
      u1 = cls inside {0, 1, 2, 3, 4, 6};
      u2 = cls inside {0, 3, 4};
      rd_o = (writer && ins[11:7] != 5'd0) ? ins[11:7] : 5'd0;
      sx = ins[31] ? 32'hFFFF_F000 : 32'd0;
      ii = sx | 32'(ins[31:20]);
      is = sx | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      ib = sx | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      iu = ins & 32'hFFFF_F000;
      ij = (ins[31] ? 32'hFFF0_0000 : 32'd0) | (32'(ins[19:12]) << 12) |
           (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      case (cls)
         1, 2, 6: imm = ii;
         3:       imm = is;
         4:       imm = ib;
         5:       imm = ij;
         7, 8:    imm = iu;
         default: imm = 32'd0;
      endcase
      if (cls == 5 || cls == 8)      a = pc;
      else if (cls == 7 || cls == 9) a = 32'd0;
      else                           a = v1;
      if (cls == 0 || cls == 4) b = v2;
      else if (cls == 5)        b = 32'd4;
      else if (cls == 9)        b = 32'd0;
      else                      b = imm;
      f3 = (cls inside {0, 1, 4}) ? ins[14:12] : 3'd0;
      f7 = (cls == 0 || (cls == 1 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))) ? ins[31:25] : 7'd0;
      fl = {cls == 0, cls inside {1, 5, 7, 8}, cls == 3, cls == 2, cls == 6,
            cls == 4, cls == 5, cls == 7, cls == 8, cls == 9};
      bnd = {a, b, f3, f7, fl, ins[14:12], rd_o, v2, imm, pc};
   endfunction

   // driver task: one clock of stimulus, plus the reference prediction for that edge
   task automatic cycle(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic fl, input logic ordy, output logic acc);
      logic [W-1:0] bnd;
      logic [4:0] rd_o, rs1, rs2;
      logic u1, u2, haz, exp_ready;
      @(negedge clk);
      rst = r; in_valid = v; in_instr = ins; in_pc = pc;
      wb_en = we; wb_rd = wrd; wb_data = wd; flush = fl; out_ready = ordy;
      #1;
      if (m_just_reset) check("reset_outputs", {out_valid, act_bundle}, '0);
      rs1 = ins[19:15];
      rs2 = ins[24:20];
      ref_decode(ins, pc, m_read(rs1, we, wrd, wd), m_read(rs2, we, wrd, wd), bnd, rd_o, u1, u2);
      haz = (u1 && rs1 != 5'd0 && m_busy[rs1] && !(we && wrd == rs1)) ||
            (u2 && rs2 != 5'd0 && m_busy[rs2] && !(we && wrd == rs2)) ||
            (rd_o != 5'd0 && m_busy[rd_o]);
      exp_ready = !fl && (!m_valid || ordy) && !haz;
      check("in_ready", 200'(in_ready), 200'(exp_ready));
      check("out_valid", 200'(out_valid), 200'(m_valid));
      acc = !r && v && exp_ready;
      m_just_reset = r;
      if (r) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_busy = 32'd0;
         m_valid = 1'b0;
         m_held_rd = 5'd0;
         exp_q.delete();
      end else begin
         if (we && wrd != 5'd0) m_regs[wrd] = wd;
         if (we) m_busy[wrd] = 1'b0;
         if (fl && m_valid && m_held_rd != 5'd0) m_busy[m_held_rd] = 1'b0;
         if (acc && rd_o != 5'd0) m_busy[rd_o] = 1'b1;
         m_busy[0] = 1'b0;
         if (acc) exp_q.push_back(bnd);
         if (fl) m_valid = 1'b0;
         else if (acc) begin m_valid = 1'b1; m_held_rd = rd_o; end
         else if (ordy) m_valid = 1'b0;
      end
   endtask

   // Writeback stimulus: retire a random in-flight destination, sometimes poke x0
   task automatic pick_wb(output logic we, output logic [4:0] wrd, output logic [31:0] wd);
      int cand[$];
      for (int i = 1; i < 32; i++) if (m_busy[i]) cand.push_back(i);
      we = 1'b0; wrd = 5'd0; wd = $urandom;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
         we = 1'b1;
         wrd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 15) == 0) begin
         we = 1'b1;
      end
   endtask

   // Present one instruction until it is taken, with writebacks draining hazards
   task automatic issue(input logic [31:0] ins);
      logic acc, we;
      logic [4:0] wrd;
      logic [31:0] wd;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
         pick_wb(we, wrd, wd);
         cycle(1'b0, 1'b1, ins, $urandom & 32'hFFFF_FFFC, we, wrd, wd, 1'b0, 1'b1, acc);
      end
      check("issue_timeout", 200'(acc), 200'(1));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      int k;
      ins = $urandom;
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 10);
      case (k)
         0: ins[6:0] = 7'h33;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h03;
         3: ins[6:0] = 7'h23;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h6F;
         6: ins[6:0] = 7'h67;  7: ins[6:0] = 7'h37;  8: ins[6:0] = 7'h17;
         9: ins[6:0] = 7'h13;  default: ins[6:0] = 7'h0F;
      endcase
      return ins;
   endfunction

   // scoreboard monitor: compare whatever bundle is presented, pop on consume or flush
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
               check("bundle_unexpected", 200'(out_valid), 200'(0));
            end else begin
               check("bundle", 200'(act_bundle), 200'(exp_q[0]));
               if (flush || out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   logic [31:0] directed [12] = '{32'h00300113, 32'h00500093, 32'h002081B3, 32'h00414283,
                                  32'hFE209EE3, 32'h40325213, 32'h12345237, 32'h00000397,
                                  32'h008000EF, 32'h000100E7, 32'h00512023, 32'hFFFFFFFF};

   initial begin
      logic acc, we, r, v, fl, ordy;
      logic [4:0] wrd;
      logic [31:0] wd;
      rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_busy = 32'd0; m_valid = 1'b0; m_held_rd = 5'd0; m_just_reset = 1'b0;

      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, acc);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, acc);

      foreach (directed[i]) issue(directed[i]);

      // Stall for three cycles, then flush the held bundle, then reset mid-stall
      issue(32'h00100313);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b1, 32'h00700393, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, acc);
      cycle(1'b0, 1'b1, 32'h00700393, 32'h40, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, acc);
      issue(32'h00100313);
      cycle(1'b0, 1'b1, 32'h00700393, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, acc);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, acc);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, acc);

      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         v = !r && ($urandom_range(0, 3) != 0);
         fl = !r && ($urandom_range(0, 15) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         if (r) begin we = 1'b0; wrd = 5'd0; wd = 32'd0; end
         else pick_wb(we, wrd, wd);
         cycle(r, v, rand_instr(), $urandom & 32'hFFFF_FFFC, we, wrd, wd, fl, ordy, acc);
      end
      for (int n = 0; n < 4; n++)
         cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, acc);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
